// File: rtl/catch_judge_if.sv
// catch_judge_if: player/sequencer-side signal bundle for the catch judge.
// master drives the light pulse, button and restart; slave is the judge.
interface catch_judge_if;
  logic        turnOn;
  logic        btn;
  logic        restart;
  logic        led;
  logic        hit;
  logic        miss;
  logic [5:0]  score;
  logic [2:0]  misses;
  logic        gameOver;
  logic [15:0] reactTime;

  modport master (
    output turnOn, btn, restart,
    input  led, hit, miss, score, misses, gameOver, reactTime
  );

  modport slave (
    input  turnOn, btn, restart,
    output led, hit, miss, score, misses, gameOver, reactTime
  );
endinterface

// File: rtl/catch_judge.sv
// catch_judge: reaction game referee. A light pulse opens a catch window; a
// debounced button press inside it scores a hit, otherwise a miss is counted.
// MAX_MISSES misses end the game until restart.
// Optional feature macro: CATCH_REACTION_TIME_EN builds the reaction-time
// capture register; without it reactTime is tied to 0.
//
// state  | meaning
// IDLE   | lamp off, waiting for a light pulse; a press here is an early miss
// ACTIVE | lamp on, window counter running
// OVER   | game finished, only restart is honoured
module catch_judge #(
  parameter int WINDOW_CYCLES   = 50_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int MAX_MISSES      = 3
) (
  input  logic          clk,
  input  logic          reset,
  catch_judge_if.slave  bus
);

  localparam int WIN_W = $clog2(WINDOW_CYCLES);
  localparam int DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST   = WIN_W'(WINDOW_CYCLES - 1);
  localparam logic [DEB_W-1:0] DEB_LOAD   = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [2:0]       MISS_LIMIT = 3'(MAX_MISSES);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_OVER} state_t;

  logic             sync1_q, sync2_q;
  logic             deb_lvl_q, deb_lvl_d;
  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
  logic             deb_prev_q;
  logic             press_q;

  state_t           state_q, state_d;
  logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
  logic [5:0]       score_q, score_d;
  logic [2:0]       misses_q, misses_d;
  logic             hit_q, hit_d;
  logic             miss_q, miss_d;

  // Two-flop synchronizer for the raw button.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= bus.btn;
      sync2_q <= sync1_q;
    end
  end

  // Debounce timer: reloads while the input agrees with the accepted level,
  // counts down while it disagrees, and flips the level at terminal count.
  always_comb begin
    deb_lvl_d = deb_lvl_q;
    deb_cnt_d = deb_cnt_q;
    if (sync2_q == deb_lvl_q) begin
      deb_cnt_d = DEB_LOAD;
    end else if (deb_cnt_q == '0) begin
      deb_lvl_d = sync2_q;
      deb_cnt_d = DEB_LOAD;
    end else begin
      deb_cnt_d = deb_cnt_q - DEB_W'(1);
    end
  end

  // Debounced level, its delayed copy and the registered rising-edge press.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      deb_lvl_q  <= 1'b0;
      deb_cnt_q  <= '0;
      deb_prev_q <= 1'b0;
      press_q    <= 1'b0;
    end else begin
      deb_lvl_q  <= deb_lvl_d;
      deb_cnt_q  <= deb_cnt_d;
      deb_prev_q <= deb_lvl_q;
      press_q    <= deb_lvl_q & ~deb_prev_q;
    end
  end

  // Game rules: window handling, hit/miss decision and score/miss counting.
  always_comb begin
    state_d   = state_q;
    win_cnt_d = win_cnt_q;
    score_d   = score_q;
    misses_d  = misses_q;
    hit_d     = 1'b0;
    miss_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.turnOn) begin
          state_d   = S_ACTIVE;
          win_cnt_d = '0;
        end else if (press_q) begin
          miss_d = 1'b1;
        end
      end
      S_ACTIVE: begin
        if (press_q) begin
          hit_d   = 1'b1;
          state_d = S_IDLE;
          if (score_q != 6'h3F) score_d = score_q + 6'd1;
        end else if (bus.turnOn) begin
          miss_d    = 1'b1;
          win_cnt_d = '0;
        end else if (win_cnt_q == WIN_LAST) begin
          miss_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          win_cnt_d = win_cnt_q + WIN_W'(1);
        end
      end
      S_OVER: begin
        if (bus.restart) begin
          state_d  = S_IDLE;
          score_d  = '0;
          misses_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // The miss that reaches the limit ends the game in the same transition.
    if (miss_d) begin
      misses_d = misses_q + 3'd1;
      if (misses_d == MISS_LIMIT) state_d = S_OVER;
    end
  end

  // Game state, counters and registered hit/miss pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      win_cnt_q <= '0;
      score_q   <= '0;
      misses_q  <= '0;
      hit_q     <= 1'b0;
      miss_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      win_cnt_q <= win_cnt_d;
      score_q   <= score_d;
      misses_q  <= misses_d;
      hit_q     <= hit_d;
      miss_q    <= miss_d;
    end
  end

  assign bus.led      = (state_q == S_ACTIVE);
  assign bus.gameOver = (state_q == S_OVER);
  assign bus.hit      = hit_q;
  assign bus.miss     = miss_q;
  assign bus.score    = score_q;
  assign bus.misses   = misses_q;

`ifdef CATCH_REACTION_TIME_EN
  logic [15:0]    react_q, react_d;
  logic [WIN_W:0] elapsed;

  // The hit edge itself closes the window, so elapsed cycles are count + 1.
  always_comb begin
    elapsed = {1'b0, win_cnt_q} + (WIN_W + 1)'(1);
    react_d = react_q;
    if (hit_d) begin
      react_d = (32'(elapsed) > 32'd65535) ? 16'hFFFF : 16'(elapsed);
    end
  end

  // Reaction time capture, held until the next hit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) react_q <= '0;
    else        react_q <= react_d;
  end

  assign bus.reactTime = react_q;
`else
  assign bus.reactTime = '0;
`endif

endmodule
